// File: rtl/btb_pkg.sv
// Shared constants and helpers for the branch target buffer: counter encodings
// and the index/tag split of a fetch PC.
package btb_pkg;

    // Largest PC width the 64-bit index/tag helpers can slice.
    localparam int unsigned BTB_PC_MAX = 32'd64;

    // Strongly not-taken: all zeros for any counter width.
    function automatic int unsigned ctr_reset_val(input int unsigned ctr_bits);
        return ctr_bits & 32'd0;
    endfunction

    function automatic int unsigned ctr_weak_taken(input int unsigned ctr_bits);
        return 32'd1 << (ctr_bits - 32'd1);
    endfunction

    function automatic int unsigned ctr_max(input int unsigned ctr_bits);
        return (32'd1 << ctr_bits) - 32'd1;
    endfunction

    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned index_bits);
        return (pc >> 2) & ((64'd1 << index_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned index_bits);
        return pc >> (index_bits + 32'd2);
    endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Combinational next-state for one saturating direction counter:
// taken moves up and sticks at the top, not-taken moves down and sticks at zero.
module btb_sat_counter
    import btb_pkg::*;
#(
    parameter int unsigned CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr_i,
    input  logic                inc_i,
    output logic [CTR_BITS-1:0] ctr_o
);

    localparam logic [CTR_BITS-1:0] CTR_TOP = CTR_BITS'(ctr_max(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_BOT = CTR_BITS'(ctr_reset_val(CTR_BITS));

    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != CTR_TOP) begin
                ctr_o = ctr_i + CTR_BITS'(1);
            end else begin
                ctr_o = ctr_i;
            end
        end else begin
            if (ctr_i != CTR_BOT) begin
                ctr_o = ctr_i - CTR_BITS'(1);
            end else begin
                ctr_o = ctr_i;
            end
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Tagged branch target buffer: registered hit/direction/next-PC prediction for the
// fetch PC, with execute-stage write-back of resolved branches and a one-cycle flush.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 5,
    parameter int unsigned PC_WIDTH   = 64,
    parameter int unsigned CTR_BITS   = 2
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                en,
    input  logic                flush,
    input  logic [PC_WIDTH-1:0] lookup_pc,
    input  logic                update_valid,
    input  logic [PC_WIDTH-1:0] update_pc,
    input  logic                update_taken,
    input  logic [PC_WIDTH-1:0] update_target,
    output logic                hit,
    output logic                predict_taken,
    output logic [PC_WIDTH-1:0] predicted_pc
);

    localparam int unsigned DEPTH = 32'd1 << INDEX_BITS;
    localparam int unsigned TAG_W = PC_WIDTH - INDEX_BITS - 32'd2;
    localparam logic [CTR_BITS-1:0] CTR_RST  = CTR_BITS'(ctr_reset_val(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(ctr_weak_taken(CTR_BITS));

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [PC_WIDTH-1:0] target;
        logic [CTR_BITS-1:0] ctr;
    } entry_t;

    entry_t entry_q [DEPTH];

    logic [INDEX_BITS-1:0] lk_idx;
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic [TAG_W-1:0]      up_tag;
    entry_t                lk_e;
    entry_t                up_e;
    entry_t                up_new;
    logic                  up_hit;
    logic                  up_we;
    logic [CTR_BITS-1:0]   ctr_nxt;

    logic                  hit_q;
    logic                  hit_d;
    logic                  taken_q;
    logic                  taken_d;
    logic [PC_WIDTH-1:0]   ppc_q;
    logic [PC_WIDTH-1:0]   ppc_d;

    assign lk_idx = INDEX_BITS'(pc_index(64'(lookup_pc), INDEX_BITS));
    assign lk_tag = TAG_W'(pc_tag(64'(lookup_pc), INDEX_BITS));
    assign up_idx = INDEX_BITS'(pc_index(64'(update_pc), INDEX_BITS));
    assign up_tag = TAG_W'(pc_tag(64'(update_pc), INDEX_BITS));

    assign lk_e   = entry_q[lk_idx];
    assign up_e   = entry_q[up_idx];
    assign up_hit = up_e.valid && (up_e.tag == up_tag);

    btb_sat_counter #(
        .CTR_BITS (CTR_BITS)
    ) u_ctr (
        .ctr_i (up_e.ctr),
        .inc_i (update_taken),
        .ctr_o (ctr_nxt)
    );

    // Prediction from the stored entry; the PC+4 carry out is dropped.
    always_comb begin
        hit_d   = lk_e.valid && (lk_e.tag == lk_tag);
        taken_d = hit_d && lk_e.ctr[CTR_BITS-1];
        if (taken_d) begin
            ppc_d = lk_e.target;
        end else begin
            ppc_d = lookup_pc + PC_WIDTH'(4);
        end
    end

    // Entry rewrite for a resolved branch; a not-taken miss leaves the table alone.
    always_comb begin
        up_new = up_e;
        up_we  = 1'b0;
        if (en && update_valid && !flush) begin
            if (up_hit) begin
                up_we      = 1'b1;
                up_new.ctr = ctr_nxt;
                if (update_taken) begin
                    up_new.target = update_target;
                end else begin
                    up_new.target = up_e.target;
                end
            end else if (update_taken) begin
                up_we         = 1'b1;
                up_new.valid  = 1'b1;
                up_new.tag    = up_tag;
                up_new.target = update_target;
                up_new.ctr    = CTR_WEAK;
            end else begin
                up_we = 1'b0;
            end
        end else begin
            up_we = 1'b0;
        end
    end

    // Table storage and output registers; flush overrides any same-cycle update.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= entry_t'{1'b0, {TAG_W{1'b0}}, {PC_WIDTH{1'b0}}, CTR_RST};
            end
            hit_q   <= 1'b0;
            taken_q <= 1'b0;
            ppc_q   <= {PC_WIDTH{1'b0}};
        end else begin
            if (flush) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    entry_q[i].valid <= 1'b0;
                end
            end else if (up_we) begin
                entry_q[up_idx] <= up_new;
            end
            if (en) begin
                hit_q   <= hit_d;
                taken_q <= taken_d;
                ppc_q   <= ppc_d;
            end
        end
    end

    assign hit           = hit_q;
    assign predict_taken = taken_q;
    assign predicted_pc  = ppc_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: directed cases plus randomized traffic
// checked against a table-level reference model.
module tb_btb_predictor;

    localparam int IB    = 4;
    localparam int CB    = 2;
    localparam int DEPTH = 1 << IB;
    localparam int CMAX  = (1 << CB) - 1;
    localparam int CHALF = 1 << (CB - 1);

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] lookup_pc = 64'd0;
    logic        update_valid = 1'b0;
    logic [63:0] update_pc = 64'd0;
    logic        update_taken = 1'b0;
    logic [63:0] update_target = 64'd0;
    logic        hit;
    logic        predict_taken;
    logic [63:0] predicted_pc;

    always #5 clk = ~clk;

    btb_predictor #(
        .INDEX_BITS (IB),
        .PC_WIDTH   (64),
        .CTR_BITS   (CB)
    ) dut (
        .clk           (clk),
        .arst          (arst),
        .en            (en),
        .flush         (flush),
        .lookup_pc     (lookup_pc),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_taken  (update_taken),
        .update_target (update_target),
        .hit           (hit),
        .predict_taken (predict_taken),
        .predicted_pc  (predicted_pc)
    );

    typedef struct {
        bit          h;
        bit          pt;
        logic [63:0] ppc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        last_e;
    bit          m_valid [DEPTH];
    logic [63:0] m_tag   [DEPTH];
    logic [63:0] m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];
    int          total = 0;
    int          bad = 0;

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic int m_idx(input logic [63:0] pc);
        return int'((pc >> 2) % 64'(DEPTH));
    endfunction

    function automatic logic [63:0] m_tagof(input logic [63:0] pc);
        return pc >> (IB + 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 0;
            m_tag[i]   = 64'd0;
            m_tgt[i]   = 64'd0;
        end
        last_e = '{1'b0, 1'b0, 64'd0};
    endtask

    // Drive one cycle of stimulus and push what the outputs must show after the edge.
    task automatic step(input bit e, input bit f, input logic [63:0] lpc, input bit uv,
                        input logic [63:0] upc, input bit ut, input logic [63:0] utgt);
        int i;
        @(negedge clk);
        en = e; flush = f; lookup_pc = lpc;
        update_valid = uv; update_pc = upc; update_taken = ut; update_target = utgt;
        if (e) begin
            i = m_idx(lpc);
            last_e.h   = m_valid[i] && (m_tag[i] == m_tagof(lpc));
            last_e.pt  = last_e.h && (m_ctr[i] >= CHALF);
            last_e.ppc = last_e.pt ? m_tgt[i] : lpc + 64'd4;
        end
        sb_q.push_back(last_e);
        if (f) begin
            for (int k = 0; k < DEPTH; k++) m_valid[k] = 1'b0;
        end else if (e && uv) begin
            i = m_idx(upc);
            if (m_valid[i] && (m_tag[i] == m_tagof(upc))) begin
                if (ut) begin
                    if (m_ctr[i] < CMAX) m_ctr[i] = m_ctr[i] + 1;
                    m_tgt[i] = utgt;
                end else if (m_ctr[i] > 0) begin
                    m_ctr[i] = m_ctr[i] - 1;
                end
            end else if (ut) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = m_tagof(upc);
                m_tgt[i]   = utgt;
                m_ctr[i]   = CHALF;
            end
        end
    endtask

    task automatic look(input logic [63:0] lpc);
        step(1'b1, 1'b0, lpc, 1'b0, 64'd0, 1'b0, 64'd0);
    endtask

    task automatic upd(input logic [63:0] upc, input bit ut, input logic [63:0] utgt);
        step(1'b1, 1'b0, 64'h1000, 1'b1, upc, ut, utgt);
    endtask

    task automatic chk(input string name, input bit h, input bit pt, input logic [63:0] ppc);
        @(posedge clk);
        #2;
        cmp({name, "_hit"}, 64'(hit), 64'(h));
        cmp({name, "_taken"}, 64'(predict_taken), 64'(pt));
        cmp({name, "_pc"}, predicted_pc, ppc);
    endtask

    task automatic chk_zero(input string name);
        cmp({name, "_hit"}, 64'(hit), 64'd0);
        cmp({name, "_taken"}, 64'(predict_taken), 64'd0);
        cmp({name, "_pc"}, predicted_pc, 64'd0);
    endtask

    function automatic logic [63:0] rand_pc();
        logic [63:0] t;
        case ($urandom_range(0, 3))
            0:       t = 64'd0;
            1:       t = 64'd1;
            2:       t = 64'h123;
            default: t = ~64'd0 >> (IB + 2);
        endcase
        return (t << (IB + 2)) | (64'($urandom_range(0, DEPTH - 1)) << 2) | 64'($urandom_range(0, 3));
    endfunction

    task automatic rand_steps(input int n);
        logic [63:0] lpc;
        logic [63:0] upc;
        for (int s = 0; s < n; s++) begin
            lpc = rand_pc();
            upc = ($urandom_range(0, 3) == 0) ? lpc : rand_pc();
            step($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, lpc,
                 1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 2) != 0),
                 {$urandom, $urandom} & ~64'd3);
        end
    endtask

    // Monitor: one scoreboard entry is due right after every active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cmp("sb_hit", 64'(hit), 64'(e.h));
                cmp("sb_taken", 64'(predict_taken), 64'(e.pt));
                cmp("sb_pc", predicted_pc, e.ppc);
            end
        end
    end

    localparam logic [63:0] ALIAS = 64'h1000 + (64'd4 << IB);

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        arst = 1'b0;

        look(64'h1000);                          chk("miss_after_reset", 1'b0, 1'b0, 64'h1004);
        step(1'b1, 1'b0, 64'h1000, 1'b1, 64'h1000, 1'b1, 64'h2000);
        chk("same_cycle_no_fwd", 1'b0, 1'b0, 64'h1004);
        look(64'h1000);                          chk("alloc_hit", 1'b1, 1'b1, 64'h2000);
        repeat (3) upd(64'h1000, 1'b1, 64'h2000);
        upd(64'h1000, 1'b0, 64'h0);
        look(64'h1000);                          chk("one_nt", 1'b1, 1'b1, 64'h2000);
        upd(64'h1000, 1'b0, 64'h0);
        look(64'h1000);                          chk("two_nt", 1'b1, 1'b0, 64'h1004);
        repeat (3) upd(64'h1000, 1'b0, 64'h0);
        upd(64'h1000, 1'b1, 64'h2000);
        look(64'h1000);                          chk("floor_t", 1'b1, 1'b0, 64'h1004);
        upd(64'h1000, 1'b1, 64'h2000);
        look(64'h1000);                          chk("floor_tt", 1'b1, 1'b1, 64'h2000);
        upd(ALIAS, 1'b1, 64'h3000);
        look(64'h1000);                          chk("alias_evict", 1'b0, 1'b0, 64'h1004);
        look(ALIAS);                             chk("alias_hit", 1'b1, 1'b1, 64'h3000);
        step(1'b1, 1'b1, ALIAS, 1'b1, 64'h1000, 1'b1, 64'h2000);
        chk("flush_same_edge", 1'b1, 1'b1, 64'h3000);
        look(64'h1000);                          chk("flush_drop", 1'b0, 1'b0, 64'h1004);
        look(ALIAS);                             chk("flush_clear", 1'b0, 1'b0, ALIAS + 64'd4);
        look(64'hFFFF_FFFF_FFFF_FFFC);           chk("wrap", 1'b0, 1'b0, 64'h0);
        step(1'b0, 1'b0, 64'h1000, 1'b1, 64'h1000, 1'b1, 64'h5000);
        chk("en0_hold", 1'b0, 1'b0, 64'h0);
        look(64'h1000);                          chk("en0_noupd", 1'b0, 1'b0, 64'h1004);
        upd(64'h1000, 1'b1, 64'h2000);
        step(1'b0, 1'b1, 64'h1000, 1'b0, 64'h0, 1'b0, 64'h0);
        look(64'h1000);                          chk("flush_en0", 1'b0, 1'b0, 64'h1004);

        rand_steps(1500);

        @(negedge clk);
        arst = 1'b1;
        #1;
        chk_zero("async_reset");
        model_reset();
        sb_q.delete();
        @(negedge clk);
        arst = 1'b0;

        rand_steps(300);
        repeat (2) @(posedge clk);
        #3;
        cmp("drain", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
